// File: rtl/gen_rr_bypass_arb.sv
// Round-robin N-way arbiter feeding a single-entry bypass buffer.
// Define GEN_RR_BYPASS_ARB_FIXPRIO_EN for fixed (lowest-index) priority.
module gen_rr_bypass_arb #(
  parameter int DW  = 64,
  parameter int NUM = 4,
  parameter int IW  = $clog2(NUM)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NUM-1:0]  valid_i,
  input  logic [NUM*DW-1:0] data_i,
  output logic [NUM-1:0]  ready_i,
  output logic            valid_o,
  output logic [DW-1:0]   data_o,
  output logic [IW-1:0]   src_o,
  input  logic            ready_o,
  input  logic            flush
);

  typedef enum logic {EMPTY, HOLD} state_t;

  state_t        state, state_n;
  logic [DW-1:0] hold_data;
  logic [IW-1:0] hold_src;
  logic [IW-1:0] ptr;
  logic [IW-1:0] sel;
  logic          any;
  logic          accept;
  logic          load;

  assign any = |valid_i;

  always_comb begin
    logic          found;
    logic [IW-1:0] idx;
    sel   = ptr;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM; i++) begin
      idx = ptr + IW'(i);
      if (!found && valid_i[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    valid_o = 1'b0;
    ready_i = '0;
    data_o  = data_i[int'(sel)*DW +: DW];
    src_o   = sel;
    accept  = 1'b0;
    load    = 1'b0;
    if (flush) begin
      state_n = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          valid_o = any;
          accept  = any;
          if (any) ready_i[sel] = 1'b1;
          if (any && !ready_o) begin
            load    = 1'b1;
            state_n = HOLD;
          end
        end
        HOLD: begin
          valid_o = 1'b1;
          data_o  = hold_data;
          src_o   = hold_src;
          if (ready_o) state_n = EMPTY;
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= EMPTY;
      hold_data <= '0;
      hold_src  <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        hold_data <= data_i[int'(sel)*DW +: DW];
        hold_src  <= sel;
      end
    end
  end

`ifdef GEN_RR_BYPASS_ARB_FIXPRIO_EN
  assign ptr = '0;
  logic unused_accept;
  assign unused_accept = accept;
`else
  always_ff @(posedge CLK) begin
    if (RST) ptr <= '0;
    else if (accept) ptr <= sel + IW'(1);
  end
`endif

endmodule

// File: tb/tb_gen_rr_bypass_arb.sv
// Directed bench for gen_rr_bypass_arb (NUM=4, DW=8).
// Inputs change 1ns after the rising edge; outputs checked 4ns later.
module tb_gen_rr_bypass_arb;

  localparam int DW  = 8;
  localparam int NUM = 4;
  localparam int IW  = 2;

  logic            CLK = 1'b0;
  logic            RST;
  logic [NUM-1:0]  valid_i;
  logic [NUM*DW-1:0] data_i;
  logic [NUM-1:0]  ready_i;
  logic            valid_o;
  logic [DW-1:0]   data_o;
  logic [IW-1:0]   src_o;
  logic            ready_o;
  logic            flush;

  int ncmp = 0;
  int nerr = 0;

  gen_rr_bypass_arb #(.DW(DW), .NUM(NUM)) dut (
    .CLK(CLK), .RST(RST),
    .valid_i(valid_i), .data_i(data_i), .ready_i(ready_i),
    .valid_o(valid_o), .data_o(data_o), .src_o(src_o),
    .ready_o(ready_o), .flush(flush)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  logic [3:0] exp_rdy [5];
  logic [7:0] exp_dat [5];

  initial begin
    RST = 1'b1; flush = 1'b0; ready_o = 1'b0;
    valid_i = '0; data_i = '0;
    tick();
    settle();
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_ready", 32'(ready_i), 0);
    chk("rst_src", 32'(src_o), 0);
    tick();
    RST = 1'b0;
    settle();
    chk("idle_valid", 32'(valid_o), 0);
    chk("idle_ready", 32'(ready_i), 0);

`ifdef GEN_RR_BYPASS_ARB_FIXPRIO_EN
    valid_i = 4'b1010; ready_o = 1'b1;
    data_i = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int c = 0; c < 6; c++) begin
      settle();
      chk($sformatf("fix_rdy%0d", c), 32'(ready_i), 32'b0010);
      chk($sformatf("fix_dat%0d", c), 32'(data_o), 32'h22);
      tick();
    end
`else
    // all four requesting: grants rotate from ptr=0
    exp_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_dat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    valid_i = 4'b1111; ready_o = 1'b1;
    data_i = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int c = 0; c < 5; c++) begin
      settle();
      chk($sformatf("rot_rdy%0d", c), 32'(ready_i), 32'(exp_rdy[c]));
      chk($sformatf("rot_dat%0d", c), 32'(data_o), 32'(exp_dat[c]));
      chk($sformatf("rot_vld%0d", c), 32'(valid_o), 1);
      tick();
    end

    // stall capture of requester 2 (ptr=1 now)
    valid_i = 4'b0100; ready_o = 1'b0;
    data_i = {8'h00, 8'hA5, 8'h00, 8'h00};
    settle();
    chk("st0_rdy", 32'(ready_i), 32'b0100);
    chk("st0_vld", 32'(valid_o), 1);
    chk("st0_dat", 32'(data_o), 32'hA5);
    tick();
    settle();
    chk("st1_rdy", 32'(ready_i), 0);
    chk("st1_dat", 32'(data_o), 32'hA5);
    chk("st1_src", 32'(src_o), 2);
    tick();
    valid_i = '0; data_i = '0;
    settle();
    chk("st2_vld", 32'(valid_o), 1);
    chk("st2_dat", 32'(data_o), 32'hA5);
    chk("st2_src", 32'(src_o), 2);
    tick();
    ready_o = 1'b1;
    settle();
    chk("st3_vld", 32'(valid_o), 1);
    chk("st3_dat", 32'(data_o), 32'hA5);
    chk("st3_rdy", 32'(ready_i), 0);
    tick();
    settle();
    chk("st4_vld", 32'(valid_o), 0);
    chk("st4_rdy", 32'(ready_i), 0);

    // hold requester 1 (ptr=3 scans 3,0,1), then flush
    valid_i = 4'b0010; ready_o = 1'b0;
    data_i = {8'h00, 8'h00, 8'h5A, 8'h00};
    tick();
    settle();
    chk("fl_rdy_acc", 32'(ready_i), 0);
    chk("fl_hold_dat", 32'(data_o), 32'h5A);
    chk("fl_hold_src", 32'(src_o), 1);
    tick();
    valid_i = '0; data_i = '0; flush = 1'b1;
    settle();
    chk("fl_vld", 32'(valid_o), 0);
    chk("fl_rdy", 32'(ready_i), 0);
    tick();
    flush = 1'b0;
    settle();
    chk("fl_after_vld", 32'(valid_o), 0);
    valid_i = 4'b1111; ready_o = 1'b1;
    data_i = {8'h44, 8'h33, 8'h22, 8'h11};
    settle();
    chk("fl_ptr_rdy", 32'(ready_i), 32'b0100);
    chk("fl_ptr_src", 32'(src_o), 2);
    tick();

    // ptr=3, only 0 and 1 valid: wrap to 0, then 1
    valid_i = 4'b0011;
    settle();
    chk("wrap_rdy0", 32'(ready_i), 32'b0001);
    chk("wrap_dat0", 32'(data_o), 32'h11);
    tick();
    settle();
    chk("wrap_rdy1", 32'(ready_i), 32'b0010);
    chk("wrap_dat1", 32'(data_o), 32'h22);
    tick();

    // flush in EMPTY blocks grant and leaves ptr=2
    valid_i = 4'b1111; flush = 1'b1;
    settle();
    chk("fle_rdy", 32'(ready_i), 0);
    chk("fle_vld", 32'(valid_o), 0);
    tick();
    flush = 1'b0;
    settle();
    chk("fle_ptr_rdy", 32'(ready_i), 32'b0100);
    chk("fle_ptr_dat", 32'(data_o), 32'h33);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
